// File: rtl/jk_pattern_driver.sv
// Excitation driver/checker for an external JK flop: divides clk into clk_slow,
// steers J/K so the flop's Q walks a stored bit pattern, and counts landing misses.
module jk_pattern_driver #(
  parameter int unsigned DIV_COUNT = 25000000,
  parameter int unsigned PAT_LEN   = 8,
  parameter logic [31:0] PATTERN   = 32'h000000B2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       q_fb,
  output logic       clk_slow,
  output logic       j,
  output logic       k,
  output logic       busy,
  output logic       done,
  output logic [7:0] err_cnt
);

  localparam int unsigned      CNT_W    = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIV_COUNT - 1);
  localparam logic [4:0]       PAT_LAST = 5'(PAT_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  // J/K that moves a flop currently at q onto d; never returns 11.
  function automatic logic [1:0] jk_for(input logic q, input logic d);
    return {~q & d, q & ~d};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [CNT_W-1:0] cnt_q;
  logic             clk_slow_q;
  logic             fall_evt;
  logic             q_meta_q, q_sync_q;

  state_t           state_q, state_d;
  logic [4:0]       idx_q, idx_d, idx_nxt;
  logic [7:0]       err_q, err_d;
  logic             j_q, j_d, k_q, k_d;
  logic             busy_q, busy_d, done_q, done_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      clk_slow_q <= 1'b0;
    end else if (cnt_q == CNT_MAX) begin
      cnt_q      <= '0;
      clk_slow_q <= ~clk_slow_q;
    end else begin
      cnt_q      <= cnt_q + CNT_W'(1);
    end
  end

  // High in the cycle whose closing edge drops clk_slow, so J/K move with that edge.
  assign fall_evt = (cnt_q == CNT_MAX) && clk_slow_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta_q <= 1'b0;
      q_sync_q <= 1'b0;
    end else begin
      q_meta_q <= q_fb;
      q_sync_q <= q_meta_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      j_q     <= j_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign idx_nxt = idx_q + 5'd1;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = err_q;
    j_d     = j_q;
    k_d     = k_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        j_d    = 1'b0;
        k_d    = 1'b0;
        busy_d = 1'b0;
        // A fall_evt in the accepting cycle is deliberately left unused.
        if (start) begin
          state_d = S_ARM;
          err_d   = '0;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_ARM: begin
        if (fall_evt) begin
          {j_d, k_d} = jk_for(q_sync_q, PATTERN[0]);
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (fall_evt) begin
          if (q_sync_q != PATTERN[idx_q]) err_d = sat_inc(err_q);
          if (idx_q == PAT_LAST) begin
            state_d = S_DONE;
            j_d     = 1'b0;
            k_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            idx_d      = idx_nxt;
            {j_d, k_d} = jk_for(q_sync_q, PATTERN[idx_nxt]);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = '0;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign clk_slow = clk_slow_q;
  assign j        = j_q;
  assign k        = k_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_jk_pattern_driver.sv
// Bench for jk_pattern_driver: an ideal/stuck JK flop model closes the loop and
// expectations are derived from the pattern bits and the excitation table.
module tb_jk_pattern_driver;

  localparam int          DIV = 4;
  localparam int          PL  = 8;
  localparam logic [31:0] PAT = 32'h000000B2;

  logic       clk = 1'b0;
  logic       rst_n, start, q_fb;
  logic       clk_slow, j, k, busy, done;
  logic [7:0] err_cnt;
  logic       start32;
  logic       clk_slow32, j32, k32, busy32, done32;
  logic [7:0] err32;

  int total = 0;
  int bad   = 0;

  // 0 ideal, 1 stuck at 0, 2 stuck at 1, 3 load preset_v
  int   mode     = 3;
  logic preset_v = 1'b0;
  logic q_model;

  always #5 clk = ~clk;

  jk_pattern_driver #(.DIV_COUNT(DIV), .PAT_LEN(PL), .PATTERN(PAT)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .q_fb(q_fb),
    .clk_slow(clk_slow), .j(j), .k(k), .busy(busy), .done(done), .err_cnt(err_cnt)
  );

  jk_pattern_driver #(.DIV_COUNT(DIV), .PAT_LEN(32), .PATTERN(32'hFFFF_FFFF)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .q_fb(1'b0),
    .clk_slow(clk_slow32), .j(j32), .k(k32), .busy(busy32), .done(done32), .err_cnt(err32)
  );

  always @(posedge clk_slow or negedge rst_n) begin
    if (!rst_n) q_model <= 1'b0;
    else begin
      case (mode)
        0: case ({j, k})
             2'b10:   q_model <= 1'b1;
             2'b01:   q_model <= 1'b0;
             2'b11:   q_model <= ~q_model;
             default: q_model <= q_model;
           endcase
        1:       q_model <= 1'b0;
        2:       q_model <= 1'b1;
        default: q_model <= preset_v;
      endcase
    end
  end
  assign q_fb = q_model;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Flop value before step i: preset for step 0, then the previous target (ideal) or the stuck level.
  function automatic logic [1:0] exp_jk(input int md, input logic q0, input int i);
    logic prev;
    logic d;
    d = PAT[i];
    if (md == 1)      prev = 1'b0;
    else if (md == 2) prev = 1'b1;
    else              prev = (i == 0) ? q0 : PAT[i-1];
    return {~prev & d, prev & ~d};
  endfunction

  function automatic int exp_err(input int md);
    int n = 0;
    if (md == 0) return 0;
    for (int i = 0; i < PL; i++) if (PAT[i] != (md == 2)) n++;
    return n;
  endfunction

  task automatic prep(input int md, input logic q0);
    mode     = 3;
    preset_v = q0;
    repeat (4 * DIV) @(negedge clk);
    mode = md;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_run(input string tag, input int md, input logic q0, input bit poke);
    logic prev_cs;
    int   n = 0, cyc = 0, extra_done = 0, jk11 = 0;
    bit   finished = 0;
    prep(md, q0);
    repeat ($urandom_range(0, 2 * DIV)) @(negedge clk);
    pulse_start();
    chk({tag, "_busy_start"}, busy, 1);
    chk({tag, "_err_clr"}, err_cnt, 0);
    prev_cs = clk_slow;
    while (!finished && cyc < 50 * DIV) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (j && k) jk11++;
      if (prev_cs && !clk_slow) begin
        n++;
        if (n <= PL) begin
          chk($sformatf("%s_jk%0d", tag, n - 1), {j, k}, exp_jk(md, q0, n - 1));
          chk($sformatf("%s_bz%0d", tag, n - 1), {busy, done}, 2'b10);
          if (poke && n == 3) start = 1'b1;
        end else begin
          chk({tag, "_done_pulse"}, {done, busy, j, k}, 4'b1000);
          finished = 1;
          if (poke) start = 1'b1;
        end
      end else if (done) extra_done++;
      prev_cs = clk_slow;
    end
    chk({tag, "_finished"}, finished, 1);
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_done_1cyc"}, {done, busy}, 2'b00);
    chk({tag, "_err"}, err_cnt, exp_err(md));
    repeat (3 * DIV) @(negedge clk);
    chk({tag, "_err_hold"}, err_cnt, exp_err(md));
    chk({tag, "_idle"}, {busy, done, j, k}, 4'b0000);
    chk({tag, "_stray_done"}, extra_done, 0);
    chk({tag, "_no_jk11"}, jk11, 0);
  endtask

  task automatic wait_falls(input int nf, output bit ok);
    logic prev_cs = clk_slow;
    int   n = 0, cyc = 0;
    while (n < nf && cyc < 4 * DIV * (nf + 2)) begin
      @(negedge clk);
      cyc++;
      if (prev_cs && !clk_slow) n++;
      prev_cs = clk_slow;
    end
    ok = (n == nf);
  endtask

  initial begin
    bit   ok;
    int   md, dcount, falls, bad_jk;
    logic q0, prev_cs;

    rst_n   = 1'b0;
    start   = 1'b0;
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {clk_slow, j, k, busy, done}, 5'b0);
    chk("rst_err", err_cnt, 0);
    chk("rst_outs32", {clk_slow32, j32, k32, busy32, done32, err32}, 13'b0);
    rst_n = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("div_phase%0d", i), clk_slow, (i / 4) % 2);
    end

    do_run("ideal_q0", 0, 1'b0, 0);
    do_run("stuck0", 1, 1'b0, 0);
    do_run("ignore_start", 0, 1'b0, 1);
    do_run("stuck1", 2, 1'b1, 1);

    // abort mid-run with idx at 3: ARM fall plus three RUN falls
    prep(1, 1'b0);
    pulse_start();
    wait_falls(4, ok);
    chk("abort_reach", ok, 1);
    @(negedge clk);
    chk("abort_pre_err", err_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {j, k, busy, done, clk_slow}, 5'b0);
    chk("abort_err", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    repeat (20 * DIV) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    do_run("after_abort", 0, 1'b1, 0);

    for (int r = 0; r < 6; r++) begin
      md = $urandom_range(0, 2);
      q0 = (md == 1) ? 1'b0 : (md == 2) ? 1'b1 : 1'(($urandom_range(0, 1)));
      do_run($sformatf("rnd%0d", r), md, q0, bit'($urandom_range(0, 1)));
    end

    // 32-bit pattern of ones against a Q stuck low: every bit misses
    start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    prev_cs = clk_slow32;
    falls   = 0;
    bad_jk  = 0;
    for (int c = 0; c < 40 * 2 * DIV && !done32; c++) begin
      @(negedge clk);
      if (prev_cs && !clk_slow32) begin
        falls++;
        if (falls <= 32 && {j32, k32} != 2'b10) bad_jk++;
      end
      prev_cs = clk_slow32;
    end
    chk("p32_done", done32, 1);
    chk("p32_falls", falls, 33);
    chk("p32_jk", bad_jk, 0);
    chk("p32_err", err32, 32);
    @(negedge clk);
    chk("p32_idle", {busy32, done32}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
